// File: rtl/snowbro2_pkg.sv
// snowbro2_pkg: shared game/bank codes, default region offsets and download FSM states
package snowbro2_pkg;
   localparam logic [7:0]  GAME_DEFAULT  = 8'd0;
   localparam logic [7:0]  GAME_SNOWBRO2 = 8'd2;
   localparam logic [1:0]  BA_PRG        = 2'd0;
   localparam logic [1:0]  BA_PCM        = 2'd1;
   localparam logic [1:0]  BA_GFX        = 2'd2;
   localparam logic [25:0] HDR_LEN_DEF   = 26'd64;
   localparam logic [25:0] PCM_START_DEF = 26'h080040;
   localparam logic [25:0] GFX_START_DEF = 26'h0C0040;
   typedef enum logic [1:0] {IDLE, HOLD, WRITE, FLUSH} state_t;
   typedef struct packed {
      logic        hdr;
      logic [1:0]  ba;
      logic [21:0] waddr;
      logic        odd;
   } region_t;
endpackage

// File: rtl/snowbro2_dwnld_decode.sv
// snowbro2_dwnld_decode: maps an ioctl byte offset to header flag, bank, word address and byte lane
module snowbro2_dwnld_decode
   import snowbro2_pkg::*;
#(
   parameter logic [25:0] HDR_LEN   = HDR_LEN_DEF,
   parameter logic [25:0] PCM_START = PCM_START_DEF,
   parameter logic [25:0] GFX_START = GFX_START_DEF
) (
   input  logic [25:0] addr,
   output region_t     rgn
);
   logic [25:0] offset;
   logic        unused_hi;
   always_comb begin
      rgn.hdr   = addr < HDR_LEN;
      rgn.ba    = addr < PCM_START ? BA_PRG : addr < GFX_START ? BA_PCM : BA_GFX;
      offset    = addr - (addr < PCM_START ? HDR_LEN : addr < GFX_START ? PCM_START : GFX_START);
      rgn.waddr = offset[22:1];
      rgn.odd   = offset[0];
   end
   assign unused_hi = ^offset[25:23];
endmodule

// File: rtl/snowbro2_dwnld.sv
// snowbro2_dwnld: packs ioctl download bytes into 16-bit SDRAM writes per region and latches GAME
module snowbro2_dwnld
   import snowbro2_pkg::*;
#(
   parameter logic [25:0] HDR_LEN   = HDR_LEN_DEF,
   parameter logic [25:0] PCM_START = PCM_START_DEF,
   parameter logic [25:0] GFX_START = GFX_START_DEF
) (
   input  logic        CLK96,
   input  logic        RESET96_N,
   input  logic        downloading,
   input  logic        ioctl_wr,
   input  logic [25:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        dwnld_busy,
   output logic [7:0]  GAME,
   output logic        overflow
);
   state_t      state, state_nx;
   region_t     live, skid, src;
   logic [25:0] skid_addr;
   logic [7:0]  skid_data, src_data;
   logic        skid_v, skid_v_nx, skid_ld, ovf_set;
   logic        live_v, match, take;
   logic [15:0] data_nx;
   logic [21:0] addr_nx;
   logic [1:0]  ba_nx, mask_nx;
   logic        unused_skid_hdr;

   snowbro2_dwnld_decode #(.HDR_LEN(HDR_LEN), .PCM_START(PCM_START), .GFX_START(GFX_START))
      u_live (.addr(ioctl_addr), .rgn(live));
   snowbro2_dwnld_decode #(.HDR_LEN(HDR_LEN), .PCM_START(PCM_START), .GFX_START(GFX_START))
      u_skid (.addr(skid_addr), .rgn(skid));
   assign unused_skid_hdr = skid.hdr;

   // header bytes never reach the packer; the skid byte always goes ahead of a live one
   assign live_v     = ioctl_wr & downloading & ~live.hdr;
   assign src        = skid_v ? skid : live;
   assign src_data   = skid_v ? skid_data : ioctl_dout;
   assign match      = src.odd && src.ba == prog_ba && src.waddr == prog_addr;
   assign take       = (skid_v | live_v) & (state == IDLE | (state == HOLD & match));
   assign prog_we    = state == WRITE || state == FLUSH;
   assign dwnld_busy = downloading | (state != IDLE) | skid_v;

   // a live byte not consumed directly is parked; it only fits if the skid is empty or just drained
   assign skid_ld   = live_v & (skid_v ? take : ~take);
   assign ovf_set   = live_v & skid_v & ~take;
   assign skid_v_nx = skid_ld | (skid_v & ~take);

   always_comb begin
      state_nx = state;
      data_nx  = prog_data;
      addr_nx  = prog_addr;
      ba_nx    = prog_ba;
      mask_nx  = prog_mask;
      if (prog_we) begin
         if (prog_rdy) state_nx = IDLE;
      end else if (take) begin
         state_nx = src.odd ? WRITE : HOLD;
         addr_nx  = src.waddr;
         ba_nx    = src.ba;
         data_nx  = src.odd ? {src_data, state == HOLD ? prog_data[7:0] : 8'h00} : {8'h00, src_data};
         mask_nx  = src.odd ? (state == HOLD ? 2'b00 : 2'b01) : 2'b11;
      end else if (state == HOLD && (skid_v | live_v | ~downloading)) begin
         state_nx = FLUSH;
         mask_nx  = 2'b10;
      end
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state     <= IDLE;
         prog_data <= '0;
         prog_addr <= '0;
         prog_ba   <= BA_PRG;
         prog_mask <= 2'b11;
         skid_v    <= 1'b0;
         skid_addr <= '0;
         skid_data <= '0;
         overflow  <= 1'b0;
         GAME      <= GAME_DEFAULT;
      end else begin
         state     <= state_nx;
         prog_data <= data_nx;
         prog_addr <= addr_nx;
         prog_ba   <= ba_nx;
         prog_mask <= mask_nx;
         skid_v    <= skid_v_nx;
         if (skid_ld) begin
            skid_addr <= ioctl_addr;
            skid_data <= ioctl_dout;
         end
         if (ovf_set) overflow <= 1'b1;
         if (ioctl_wr && downloading && ioctl_addr == '0) GAME <= ioctl_dout;
      end
   end
endmodule

// File: tb/tb_snowbro2_dwnld.sv
// tb_snowbro2_dwnld: random and directed byte streams checked against an in-order packing model
module tb_snowbro2_dwnld;
   localparam int HDR = 64, PCM = 'h080040, GFX = 'h0C0040;
   logic        clk = 0, rst_n = 1, downloading = 0, ioctl_wr = 0;
   logic [25:0] ioctl_addr = 0;
   logic [7:0]  ioctl_dout = 0;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask, prog_ba;
   logic        prog_we, prog_rdy, dwnld_busy, overflow;
   logic [7:0]  game;
   logic        auto_rdy = 0, man_rdy = 0, rdy_hold = 0;
   int          rdy_wait = 0;
   logic [41:0] got [1024];
   int          n_got = 0, n_unstable = 0;
   logic        prev_we = 0;
   logic [41:0] prev_bus = 0;
   logic [41:0] exp_q[$];
   int          n_chk = 0;
   logic [7:0]  exp_game = 0;
   logic        pend_v = 0;
   logic [1:0]  pend_b = 0;
   int          pend_o = 0;
   logic [7:0]  pend_d = 0;
   int          n_cmp = 0, n_err = 0, lowcnt = 0;
   logic [25:0] ra;

   assign prog_rdy = auto_rdy | man_rdy;
   always #5 clk = ~clk;

   snowbro2_dwnld dut (
      .CLK96(clk), .RESET96_N(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
      .dwnld_busy(dwnld_busy), .GAME(game), .overflow(overflow));

   // SDRAM side: acknowledge each write after 0..3 extra cycles unless held off
   always @(posedge clk) begin
      #2;
      if (auto_rdy) auto_rdy = 0;
      else if (prog_we && !rdy_hold) begin
         if (rdy_wait == 0) begin
            auto_rdy = 1;
            rdy_wait = $urandom_range(0, 3);
         end else rdy_wait--;
      end
   end

   always @(negedge clk) begin
      if (prog_we && prog_rdy && n_got < 1024) begin
         got[n_got] = {prog_ba, prog_addr, prog_data, prog_mask};
         n_got++;
      end
      if (prog_we && prev_we && {prog_ba, prog_addr, prog_data, prog_mask} != prev_bus) n_unstable++;
      prev_we  = prog_we;
      prev_bus = {prog_ba, prog_addr, prog_data, prog_mask};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] bank_of(input int a);
      return a < PCM ? 2'd0 : a < GFX ? 2'd1 : 2'd2;
   endfunction

   function automatic int off_of(input int a);
      return a - (a < PCM ? HDR : a < GFX ? PCM : GFX);
   endfunction

   function automatic logic [41:0] masked(input logic [41:0] g);
      logic [41:0] m;
      m = g;
      if (g[0]) m[9:2] = 0;
      if (g[1]) m[17:10] = 0;
      return m;
   endfunction

   task automatic m_flush();
      if (pend_v) exp_q.push_back({pend_b, 22'(pend_o / 2), 8'h00, pend_d, 2'b10});
      pend_v = 0;
   endtask

   task automatic m_byte(input int a, input logic [7:0] d);
      logic [1:0] b;
      int o;
      if (a < HDR) begin
         if (a == 0) exp_game = d;
         return;
      end
      b = bank_of(a);
      o = off_of(a);
      if (o % 2 == 1 && pend_v && pend_b == b && pend_o / 2 == o / 2) begin
         exp_q.push_back({b, 22'(o / 2), d, pend_d, 2'b00});
         pend_v = 0;
      end else if (o % 2 == 1) begin
         m_flush();
         exp_q.push_back({b, 22'(o / 2), d, 8'h00, 2'b01});
      end else begin
         m_flush();
         pend_v = 1; pend_b = b; pend_o = o; pend_d = d;
      end
   endtask

   task automatic send(input int a, input logic [7:0] d, input logic keep);
      @(posedge clk); #1;
      ioctl_addr = 26'(a); ioctl_dout = d; ioctl_wr = 1;
      @(posedge clk); #1;
      ioctl_wr = 0;
      if (keep) m_byte(a, d);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (n_got < exp_q.size() && t < 400) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_count"}, 64'(n_got), 64'(exp_q.size()));
      for (int k = n_chk; k < n_got && k < exp_q.size(); k++) check(tag, 64'(masked(got[k])), 64'(exp_q[k]));
      n_chk = n_got;
   endtask

   initial begin
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", prog_we, 0);
      check("rst_mask", prog_mask, 2'b11);
      check("rst_addr", prog_addr, 0);
      check("rst_data", prog_data, 0);
      check("rst_ba", prog_ba, 0);
      check("rst_game", game, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", dwnld_busy, 0);
      rst_n = 1;
      @(posedge clk); #1 downloading = 1;

      send(0, 8'h02, 1);
      check("game_latch", game, exp_game);
      send('h40, 8'h34, 1);
      send('h41, 8'h12, 1);
      check("latency_we", prog_we, 1);
      drain("pair");

      send(PCM, 8'hAA, 1);
      send(PCM + 3, 8'h55, 1);
      drain("pcm_flush");

      rdy_hold = 1;
      send('h200, 8'h01, 1);
      send('h201, 8'h02, 1);
      repeat (3) @(posedge clk);
      #1;
      man_rdy = 1; ioctl_addr = 'h202; ioctl_dout = 8'h03; ioctl_wr = 1;
      @(posedge clk); #1;
      man_rdy = 0; ioctl_wr = 0;
      m_byte('h202, 8'h03);
      send('h203, 8'h04, 1);
      rdy_hold = 0;
      drain("coincide");
      check("coincide_ovf", overflow, 0);

      rdy_hold = 1;
      send('h300, 8'h11, 1);
      send('h301, 8'h22, 1);
      send('h302, 8'h33, 1);
      send('h303, 8'h44, 0);
      check("ovf_set", overflow, 1);
      lowcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (!prog_we) lowcnt++;
      end
      check("we_held", 64'(lowcnt), 0);
      rdy_hold = 0;
      drain("skid");

      ra = 26'h1000;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: ra = ra + 1;
            6: ra = 26'(PCM + $urandom_range(0, 4095));
            7: ra = 26'(GFX + $urandom_range(0, 4095));
            8: ra = 26'(HDR + $urandom_range(0, 4095));
            default: ra = $urandom_range(0, 1) ? 26'(PCM - 2) : 26'(GFX - 2);
         endcase
         send(int'(ra), 8'($urandom), 1);
         repeat ($urandom_range(12, 18)) @(posedge clk);
      end
      drain("random");

      send(GFX + 'h400, 8'h5A, 1);
      rdy_hold = 1;
      downloading = 0;
      m_flush();
      repeat (5) @(posedge clk);
      #1;
      check("end_busy", dwnld_busy, 1);
      check("end_we", prog_we, 1);
      rdy_hold = 0;
      drain("gfx_end");
      check("idle_busy", dwnld_busy, 0);

      @(posedge clk); #1 downloading = 1;
      send(0, 8'h07, 1);
      check("game_relatch", game, exp_game);
      check("ovf_kept", overflow, 1);

      rdy_hold = 1;
      send('h500, 8'hA1, 1);
      send('h501, 8'hB2, 1);
      repeat (2) @(posedge clk);
      #3 rst_n = 0;
      #1;
      check("arst_we", prog_we, 0);
      check("arst_mask", prog_mask, 2'b11);
      check("arst_addr", prog_addr, 0);
      check("arst_data", prog_data, 0);
      check("arst_ovf", overflow, 0);
      check("arst_game", game, 0);
      while (exp_q.size() > n_got) void'(exp_q.pop_back());
      n_chk = n_got;
      pend_v = 0;
      exp_game = 0;
      @(posedge clk); #1;
      rst_n = 1;
      rdy_hold = 0;
      send(PCM + 8, 8'hC3, 1);
      send(PCM + 9, 8'hD4, 1);
      drain("post_rst");
      check("stable", 64'(n_unstable), 0);

      downloading = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/snowbro2_dwnld.md
# snowbro2_dwnld

ROM download formatter between the MiSTer ioctl byte stream and the SDRAM programming port. It strips and decodes the ROM header, latches the GAME selector, packs byte pairs into 16-bit words, and routes each word to an SDRAM bank and word address by region: 68K program, PCM, GFX. It drives `prog_*` and `dwnld_busy` toward the SDRAM controller and feeds `GAME` to the CPU, video and sound blocks.

## Interface
- `HDR_LEN`, 64: header bytes; never written to SDRAM.
- `PCM_START`, 26'h080040: ioctl byte offset where the PCM region begins.
- `GFX_START`, 26'h0C0040: ioctl byte offset where the GFX region begins. The program region spans HDR_LEN..PCM_START-1.
- `CLK96`  in  1  96 MHz SDRAM-domain clock.
- `RESET96_N`  in  1  asynchronous, active-low reset.
- `downloading`  in  1  download window active.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  26  byte offset.
- `ioctl_dout`  in  8  byte data.
- `prog_addr`  out  22  SDRAM word address within the bank.
- `prog_data`  out  16  word data.
- `prog_mask`  out  2  per-byte write mask, 1 = byte not written.
- `prog_ba`  out  2  bank: 0 = program, 1 = PCM, 2 = GFX.
- `prog_we`  out  1  write request, held until `prog_rdy`.
- `prog_rdy`  in  1  one-cycle write-complete pulse.
- `dwnld_busy`  out  1  download or pending write in progress.
- `GAME`  out  8  game selector, from header byte 0.
- `overflow`  out  1  sticky; a byte was lost.

## Operation
- Region decode by `ioctl_addr`:
  - below HDR_LEN: header.
  - below PCM_START: bank 0, offset = addr-HDR_LEN.
  - below GFX_START: bank 1, offset = addr-PCM_START.
  - otherwise: bank 2, offset = addr-GFX_START.
  - Word address = offset[22:1].
- Header: byte at addr 0 latches `GAME`. All other header bytes are ignored. `GAME` holds its value after the download ends.
- Packing:
  - Even-offset byte goes to `prog_data[7:0]` and is held in state HOLD.
  - Odd-offset byte completes the word in `[15:8]` and issues a write with mask 2'b00.
  - An odd byte with no matching held even byte (or at a different word address) issues a write with mask 2'b01.
  - A held even byte is flushed with mask 2'b10 when any of these occurs: the next byte targets a different word, the region changes, or `downloading` falls.
- FSM states:
  - IDLE: HOLD on an even byte; WRITE on an odd byte.
  - HOLD: WRITE on the completing odd byte; FLUSH on a non-matching byte, with that byte parked in the skid register.
  - WRITE: assert `prog_we`. On `prog_rdy`, go to IDLE, or process the skid byte if one is valid.
  - FLUSH: behaves as WRITE; afterwards process the skid byte.
- Skid register: one byte plus its address. It accepts an `ioctl_wr` that arrives while the FSM is in WRITE or FLUSH. If a byte arrives while the skid is already full, the byte is dropped and `overflow` is set; only reset clears it.
- `dwnld_busy` = `downloading` | (state≠IDLE) | skid valid.
- If `downloading` rises again, `GAME` is re-latched from the new header byte 0. `overflow` is kept.

## Timing
- Reset values:
  - `prog_we`=0, `prog_mask`=2'b11, `prog_addr`=0, `prog_data`=0, `prog_ba`=0.
  - `GAME`=0, `overflow`=0, FSM in IDLE, skid empty.
- Reset asserted mid-write: `prog_we` drops asynchronously and the pending word is lost.
- Latency: `prog_we` rises on the first CLK96 edge after the completing `ioctl_wr` is sampled.
- All `prog_*` outputs are stable from the `prog_we` rise until the cycle after `prog_rdy`.
- `prog_we` falls in the cycle after `prog_rdy` is sampled. A skid byte that completes a word can raise `prog_we` again one cycle later.
- `prog_rdy` sampled while `prog_we`=0 is ignored.
- A `prog_rdy` coinciding with `ioctl_wr` completes the current write first, then accepts the byte. The byte is not dropped.
- `GAME` updates the cycle after the header-byte-0 strobe.

## Structure
- Shared package `snowbro2_pkg`:
  - GAME codes DEFAULT=0, SNOWBRO2=2.
  - Bank codes BA_PRG=0, BA_PCM=1, BA_GFX=2.
  - Default region offsets.
  - FSM state enum.
- One sub-module, `snowbro2_dwnld_decode`: combinational region/bank/word-address/parity decode. It is instantiated twice: on the live input and on the skid register.

## Test plan
- Bytes 0x02 at addr 0, then 0x34/0x12 at addr 0x40/0x41 → `GAME`=2; one write with `prog_ba`=0, `prog_addr`=0, `prog_data`=0x1234, `prog_mask`=2'b00.
- Even byte 0xAA at PCM_START followed by an odd byte at PCM_START+3 → flush of bank 1, addr 0, mask 2'b10, data[7:0]=0xAA; then a write at addr 1 with mask 2'b01.
- `prog_rdy` held off 20 cycles while two more bytes arrive → first byte enters the skid, second sets `overflow`=1; `prog_we` stays high throughout.
- Byte at GFX_START+0x400 (even) then `downloading` falls → flush of bank 2, addr 0x200, mask 2'b10; `dwnld_busy` stays 1 until that write's `prog_rdy`.
- `RESET96_N` pulsed low while `prog_we`=1 → all outputs return to reset values immediately; the next byte starts cleanly from IDLE.
